// File: rtl/snitch_hwpe_ctrl_pkg.sv
// Shared types and default widths for the HWPE control-port arbiter.
package snitch_hwpe_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam int unsigned DefaultNrCores       = 8;
    localparam int unsigned DefaultAddrWidth     = 32;
    localparam int unsigned DefaultDataWidth     = 32;
    localparam int unsigned DefaultIdWidth       = 8;
    localparam int unsigned DefaultTimeoutCycles = 1024;

endpackage

// File: rtl/snitch_hwpe_ctrl_rr_arb.sv
// Round-robin selector: first requester at or after the pointer, wrapping at NrCores-1.
module snitch_hwpe_ctrl_rr_arb
    import snitch_hwpe_ctrl_pkg::*;
#(
    parameter  int unsigned NrCores  = DefaultNrCores,
    localparam int unsigned IdxWidth = $clog2(NrCores)
) (
    input  logic [NrCores-1:0]  req_i,
    input  logic [IdxWidth-1:0] ptr_i,
    output logic [NrCores-1:0]  gnt_o,
    output logic [IdxWidth-1:0] idx_o,
    output logic                valid_o
);

    logic [IdxWidth-1:0] cand;

    // Scan NrCores positions starting from the pointer; the first hit wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NrCores; i++) begin
            cand = IdxWidth'((32'(ptr_i) + i) % NrCores);
            if (!valid_o && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snitch_hwpe_ctrl_arbiter.sv
// Serialises core accesses onto a single HWPE control port, one transaction in flight.
// Optional response watchdog: define SNITCH_HWPE_CTRL_TIMEOUT_EN.
module snitch_hwpe_ctrl_arbiter
    import snitch_hwpe_ctrl_pkg::*;
#(
    parameter int unsigned NrCores       = DefaultNrCores,
    parameter int unsigned AddrWidth     = DefaultAddrWidth,
    parameter int unsigned DataWidth     = DefaultDataWidth,
    parameter int unsigned IdWidth       = DefaultIdWidth,
    parameter int unsigned TimeoutCycles = DefaultTimeoutCycles
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NrCores-1:0]     core_q_valid_i,
    output logic [NrCores-1:0]     core_q_ready_o,
    input  logic [AddrWidth-1:0]   core_q_addr_i [NrCores],
    input  logic [NrCores-1:0]     core_q_write_i,
    input  logic [DataWidth/8-1:0] core_q_strb_i [NrCores],
    input  logic [DataWidth-1:0]   core_q_data_i [NrCores],
    output logic [NrCores-1:0]     core_p_valid_o,
    output logic [DataWidth-1:0]   core_p_data_o,
    output logic                   core_p_error_o,
    output logic                   periph_req_o,
    input  logic                   periph_gnt_i,
    output logic [AddrWidth-1:0]   periph_add_o,
    output logic                   periph_wen_o,
    output logic [DataWidth/8-1:0] periph_be_o,
    output logic [DataWidth-1:0]   periph_data_o,
    output logic [IdWidth-1:0]     periph_id_o,
    input  logic                   periph_r_valid_i,
    input  logic [DataWidth-1:0]   periph_r_data_i,
    input  logic [IdWidth-1:0]     periph_r_id_i,
    output logic                   busy_o
);

    localparam int unsigned IdxWidth = $clog2(NrCores);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NrCores - 1);

    // Reject configurations the owner-ID encoding or watchdog cannot support.
    if (NrCores < 2 || NrCores > 16 || IdWidth < IdxWidth || TimeoutCycles < 1) begin : gen_bad_cfg
        $error("snitch_hwpe_ctrl_arbiter: unsupported parameter combination");
    end

    state_e                 state_q, state_d;
    logic [IdxWidth-1:0]    ptr_q, ptr_d;
    logic [IdxWidth-1:0]    owner_q, owner_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic                   write_q, write_d;
    logic [DataWidth/8-1:0] strb_q, strb_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic [DataWidth-1:0]   rdata_q, rdata_d;
    logic                   pulse_q, pulse_d;

    logic [NrCores-1:0]     arb_gnt;
    logic [IdxWidth-1:0]    arb_idx;
    logic                   arb_valid;
    logic                   resp_match;

`ifdef SNITCH_HWPE_CTRL_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    snitch_hwpe_ctrl_rr_arb #(
        .NrCores (NrCores)
    ) i_rr_arb (
        .req_i   (core_q_valid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign resp_match = periph_r_valid_i && (periph_r_id_i == IdWidth'(owner_q));

    // Next-state logic: accept in IDLE, hold request until grant, wait for matching response.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        write_d = write_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        pulse_d = 1'b0;
`ifdef SNITCH_HWPE_CTRL_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d = StReq;
                    owner_d = arb_idx;
                    addr_d  = core_q_addr_i[arb_idx];
                    write_d = core_q_write_i[arb_idx];
                    strb_d  = core_q_strb_i[arb_idx];
                    wdata_d = core_q_data_i[arb_idx];
                    ptr_d   = (arb_idx == LastIdx) ? '0 : arb_idx + 1'b1;
                end
            end
            StReq: begin
                if (periph_gnt_i) begin
                    state_d = StResp;
`ifdef SNITCH_HWPE_CTRL_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StResp: begin
                if (resp_match) begin
                    state_d = StIdle;
                    rdata_d = periph_r_data_i;
                    pulse_d = 1'b1;
                end
`ifdef SNITCH_HWPE_CTRL_TIMEOUT_EN
                else if (cnt_q == CntWidth'(TimeoutCycles - 1)) begin
                    state_d = StIdle;
                    rdata_d = '0;
                    pulse_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // State and payload registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            pulse_q <= 1'b0;
`ifdef SNITCH_HWPE_CTRL_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            pulse_q <= pulse_d;
`ifdef SNITCH_HWPE_CTRL_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Output decode; wen is gated so the idle/reset view of the port is all-zero.
    always_comb begin
        core_q_ready_o = (state_q == StIdle && !rst_i) ? arb_gnt : '0;
        periph_req_o   = (state_q == StReq);
        periph_add_o   = addr_q;
        periph_wen_o   = (state_q == StReq) ? ~write_q : 1'b0;
        periph_be_o    = strb_q;
        periph_data_o  = wdata_q;
        periph_id_o    = IdWidth'(owner_q);
        core_p_valid_o = pulse_q ? ({{(NrCores - 1){1'b0}}, 1'b1} << owner_q) : '0;
        core_p_data_o  = rdata_q;
`ifdef SNITCH_HWPE_CTRL_TIMEOUT_EN
        core_p_error_o = err_q;
`else
        core_p_error_o = 1'b0;
`endif
        busy_o         = (state_q != StIdle);
    end

endmodule

// File: doc/snitch_hwpe_ctrl_arbiter.md
SNITCH_HWPE_CTRL_ARBITER -- requirements
Module: snitch_hwpe_ctrl_arbiter

Interface
REQ-001 SHALL have parameter NrCores, default 8, number of requesting cores (2..16).
REQ-002 SHALL have parameter AddrWidth, default 32, control-port address width.
REQ-003 SHALL have parameter DataWidth, default 32, control-port data width.
REQ-004 SHALL have parameter IdWidth, default 8, HWPE periph ID width (>= clog2(NrCores)).
REQ-005 SHALL have parameter TimeoutCycles, default 1024, response watchdog limit (used only with the macro in REQ-030).
REQ-006 SHALL have port clk_i, input, 1, sole clock; one clock; reset is synchronous and active-high.
REQ-007 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports core_q_valid_i / core_q_ready_o, in/out, NrCores, per-core request handshake.
REQ-009 SHALL have ports core_q_addr_i [NrCores][AddrWidth], core_q_write_i [NrCores], core_q_strb_i [NrCores][DataWidth/8], core_q_data_i [NrCores][DataWidth], all inputs, request payload.
REQ-010 SHALL have ports core_p_valid_o, out, NrCores, one-hot response strobe; core_p_data_o, out, DataWidth; core_p_error_o, out, 1.
REQ-011 SHALL have ports periph_req_o out 1, periph_gnt_i in 1, periph_add_o out AddrWidth, periph_wen_o out 1 (0 = write), periph_be_o out DataWidth/8, periph_data_o out DataWidth, periph_id_o out IdWidth.
REQ-012 SHALL have ports periph_r_valid_i in 1, periph_r_data_i in DataWidth, periph_r_id_i in IdWidth, HWPE response.
REQ-013 SHALL have port busy_o, out, 1, high whenever FSM is not IDLE.

Function
REQ-014 SHALL serialize core accesses to the single HWPE control port, at most one transaction outstanding.
REQ-015 SHALL implement FSM states IDLE, REQ, RESP.
REQ-016 IDLE: if any core_q_valid_i set, SHALL assert core_q_ready_o for exactly one winner (round-robin from pointer), register payload and owner index, go to REQ next cycle; core_q_ready_o SHALL be 0 outside IDLE.
REQ-017 Round-robin: after acceptance pointer SHALL become (winner+1) mod NrCores; search wraps from NrCores-1 to 0.
REQ-018 REQ: periph_req_o SHALL be 1 with registered payload held stable; periph_wen_o = ~write; periph_id_o = owner index zero-extended; on periph_gnt_i go to RESP.
REQ-019 RESP: on periph_r_valid_i with periph_r_id_i equal to registered ID, SHALL register data and go to IDLE; core_p_valid_o[owner] SHALL pulse 1 cycle in the following cycle with core_p_error_o = 0.
REQ-020 Writes SHALL also wait for periph_r_valid_i before completion.
REQ-021 periph_r_valid_i in IDLE/REQ or with mismatching ID SHALL be ignored.
REQ-022 Latency, zero-wait HWPE: accept cycle N, periph_req_o cycle N+1, r_valid at N+2, core_p_valid_o at N+3; new acceptance possible at N+3.
REQ-023 Simultaneous requests from all cores SHALL each be served exactly once within NrCores transactions.
REQ-024 A core dropping core_q_valid_i before acceptance SHALL not be served; no payload captured.

Reset
REQ-025 On rst_i, next edge: FSM = IDLE, pointer = 0, payload regs = 0, all outputs 0 (core_q_ready_o follows REQ-016 combinationally once out of reset).
REQ-026 Reset mid-transaction SHALL drop periph_req_o at the next edge and issue no core response; late HWPE responses SHALL be ignored per REQ-021.
REQ-027 During rst_i high, core_q_ready_o SHALL be 0.

Configuration
REQ-028 Macro SNITCH_HWPE_CTRL_TIMEOUT_EN SHALL control the response watchdog.
REQ-029 Without it: no counter, RESP waits indefinitely, core_p_error_o tied 0.
REQ-030 With it: counter cleared on RESP entry, increments each RESP cycle; reaching TimeoutCycles without matching response SHALL go to IDLE and pulse core_p_valid_o[owner] with core_p_error_o = 1, core_p_data_o = 0.

Structure
REQ-031 Package snitch_hwpe_ctrl_pkg SHALL hold the FSM state enum and default width constants.
REQ-032 Round-robin selection SHALL be sub-module snitch_hwpe_ctrl_rr_arb (request vector, pointer -> one-hot grant, index, valid).

Verification
REQ-033 Single read core 2, addr 0x20, zero-wait HWPE, r_data 0xCAFE0001 -> periph_id_o 2, core_p_valid_o = 0x04 at N+3, data 0xCAFE0001.
REQ-034 All 8 cores valid, pointer 0 -> acceptance order 0..7, then pointer back to 0.
REQ-035 Write core 5, gnt delayed 3 cycles -> payload stable for 4 REQ cycles, periph_wen_o 0, completion only after r_valid.
REQ-036 r_valid with id 3 while owner 1 -> ignored; id 1 response completes core 1.
REQ-037 rst_i in RESP, then r_valid -> no core_p_valid_o, FSM IDLE, pointer 0.
REQ-038 With SNITCH_HWPE_CTRL_TIMEOUT_EN, TimeoutCycles 16, no r_valid -> error pulse to owner after 16 RESP cycles, data 0.
